// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte requesters.
// Optional burst locking is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        tx_data,
  output logic              tx_latch,
  input  logic              tx_busy,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              active
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gidx, g_hi, g_lo;
  logic             found, found_hi, found_lo;
  logic             grant_fire;
  logic [7:0]       gdata;
  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  owner_onehot;

  assign owner_onehot = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx;

`ifdef UART_ARB_LOCK_EN
  logic locked;
  // A burst owner shuts out everyone else until it sends its last byte.
  assign elig = req_valid & (locked ? owner_onehot : {NREQ{1'b1}});
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign elig        = req_valid;
`endif

  // Two-pass search: indices above ptr first, then wrap to the rest.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    g_hi     = '0;
    g_lo     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (elig[i]) begin
        if (i > int'(ptr)) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            g_hi     = IDX_W'(i);
          end
        end else if (!found_lo) begin
          found_lo = 1'b1;
          g_lo     = IDX_W'(i);
        end
      end
    end
    found = found_hi | found_lo;
    gidx  = found_hi ? g_hi : g_lo;
  end

  always_comb begin
    gdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDX_W'(i) == gidx) gdata = req_data[8*i +: 8];
    end
  end

  assign grant_fire = (state == IDLE) && !tx_busy && found && !rst;
  assign req_ready  = grant_fire ? ({{(NREQ-1){1'b0}}, 1'b1} << gidx) : '0;
  assign tx_latch   = (state == ISSUE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (grant_fire) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) state_nxt = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx_data   <= '0;
      grant_idx <= '0;
      active    <= 1'b0;
      ptr       <= IDX_W'(NREQ-1);
`ifdef UART_ARB_LOCK_EN
      locked    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (grant_fire) begin
        tx_data   <= gdata;
        grant_idx <= gidx;
        active    <= 1'b1;
`ifdef UART_ARB_LOCK_EN
        locked    <= !req_last[gidx];
`endif
      end
      if (state == WAIT_DONE && !tx_busy) begin
        active <= 1'b0;
`ifdef UART_ARB_LOCK_EN
        // Mid-burst the pointer stays put so fairness resumes after the owner.
        if (!locked) ptr <= grant_idx;
`else
        ptr <= grant_idx;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural 12-cycle transmitter busy model.
module tb_uart_tx_arbiter;
  localparam int NREQ  = 4;
  localparam int IDX_W = 2;
  localparam int FRAME = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        tx_data;
  logic              tx_latch;
  logic              tx_busy;
  logic [IDX_W-1:0]  grant_idx;
  logic              active;

  logic       force_busy;
  logic       busy_en;
  int         busy_cnt = 0;
  int         n_tests  = 0;
  int         n_fail   = 0;
  int         lat_cnt  = 0;
  int         rdy_cnt  = 0;
  logic [7:0] sb[$];

  uart_tx_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_latch(tx_latch), .tx_busy(tx_busy), .grant_idx(grant_idx), .active(active)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy rises the cycle after the latch, lasts FRAME cycles.
  always @(posedge clk) begin
    if (busy_en && tx_latch) busy_cnt <= FRAME;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = force_busy | (busy_cnt != 0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_latch) begin
        lat_cnt++;
        if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk("tx_data", {24'd0, tx_data}, {24'd0, sb.pop_front()});
      end
      if (req_ready != '0) begin
        rdy_cnt++;
        chk("rdy_onehot", $countones(req_ready), 1);
        chk("rdy_only_idle", {31'd0, active}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    @(negedge clk);
    while (active && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n, lat0, rdy0, i0, i1;
    logic [7:0] a_bytes [3];
    logic       a_last  [3];
    logic [NREQ-1:0] hs;
    a_bytes = '{8'hA0, 8'hA1, 8'hA2};
    a_last  = '{1'b0, 1'b0, 1'b1};
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
    force_busy = 1'b0; busy_en = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_latch", tx_latch, 0);
    chk("rst_active", active, 0);
    chk("rst_grant", grant_idx, 0);
    chk("rst_txdata", tx_data, 0);

    // Single requester, first-frame latency.
    tick();
    rst = 1'b0; req_valid = 4'b0001; req_data[7:0] = 8'h41; sb.push_back(8'h41);
    @(negedge clk);
    chk("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t1_latch", tx_latch, 1);
    chk("t1_grant", grant_idx, 0);
    chk("t1_active", active, 1);
    wait_idle(60, n);
    chk("t1_active_len", n, 13);

    // All four valid after reset: strict rotation 0,1,2,3,0.
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    req_valid = 4'b1111; req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    foreach (a_bytes[k]) if (k < 0) sb.push_back(8'h00);
    sb.push_back(8'h10); sb.push_back(8'h11); sb.push_back(8'h12);
    sb.push_back(8'h13); sb.push_back(8'h10);
    rdy0 = rdy_cnt;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("t2_timeout", 32'd0, 32'd1);
    req_valid = '0;
    wait_idle(60, n);
    chk("t2_ready_cnt", rdy_cnt - rdy0, 5);
    chk("t2_last_grant", grant_idx, 0);

    // Busy held across reset release blocks granting.
    tick(); rst = 1'b1; force_busy = 1'b1;
    req_valid = 4'b0100; req_data[23:16] = 8'h22;
    tick(); rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("t3_no_ready", req_ready, 0);
    end
    tick(); force_busy = 1'b0; sb.push_back(8'h22);
    @(negedge clk);
    chk("t3_ready", req_ready, 4'b0100);
    tick(); req_valid = '0;
    @(negedge clk);
    chk("t3_grant", grant_idx, 2);
    wait_idle(60, n);

    // Valid pulsed during WAIT_DONE then dropped: no transfer.
    tick(); req_valid = 4'b0001; req_data[7:0] = 8'h55; sb.push_back(8'h55);
    tick(); req_valid = '0;
    repeat (5) tick();
    lat0 = lat_cnt;
    req_valid = 4'b0010; req_data[15:8] = 8'h66;
    @(negedge clk);
    chk("t4_no_ready", req_ready, 0);
    tick(); req_valid = '0;
    wait_idle(60, n);
    repeat (10) tick();
    chk("t4_no_latch", lat_cnt - lat0, 0);
    chk("t4_idle", active, 0);

    // Reset during WAIT_BUSY, then index 0 first.
    tick(); busy_en = 1'b0; req_valid = 4'b1000; req_data[31:24] = 8'h77; sb.push_back(8'h77);
    tick(); req_valid = '0;
    tick();
    @(negedge clk);
    chk("t5_waitbusy_active", active, 1);
    tick(); rst = 1'b1;
    tick();
    @(negedge clk);
    chk("t5_rst_active", active, 0);
    chk("t5_rst_latch", tx_latch, 0);
    chk("t5_rst_grant", grant_idx, 0);
    tick(); rst = 1'b0; busy_en = 1'b1;
    req_valid = 4'b1111; req_data = {8'h13, 8'h12, 8'h11, 8'h10}; sb.push_back(8'h10);
    @(negedge clk);
    chk("t5_ready", req_ready, 4'b0001);
    tick(); req_valid = '0;
    wait_idle(60, n);

    // Burst from req0 against req1.
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
`ifdef UART_ARB_LOCK_EN
    sb.push_back(8'hA0); sb.push_back(8'hA1); sb.push_back(8'hA2); sb.push_back(8'hB0);
`else
    sb.push_back(8'hA0); sb.push_back(8'hB0); sb.push_back(8'hA1); sb.push_back(8'hA2);
`endif
    i0 = 0; i1 = 0; n = 0;
    while ((i0 < 3 || i1 < 1) && n < 400) begin
      req_valid = {2'b00, i1 < 1, i0 < 3};
      req_data[7:0]  = (i0 < 3) ? a_bytes[i0] : 8'h00;
      req_last[0]    = (i0 < 3) ? a_last[i0] : 1'b0;
      req_data[15:8] = 8'hB0;
      req_last[1]    = 1'b1;
      @(negedge clk);
      hs = req_valid & req_ready;
      tick();
      if (hs[0]) i0++;
      if (hs[1]) i1++;
      n++;
    end
    if (n >= 400) chk("t6_timeout", 32'd0, 32'd1);
    req_valid = '0;
    wait_idle(60, n);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
